// File: rtl/key_event_pkg.sv
// Shared definitions for the key event controller: bus widths, register map and debounce state.
package key_event_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_LEVEL   = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_MASK    = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_PRESS   = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    UP        = 2'd0,
    WAIT_DOWN = 2'd1,
    DOWN      = 2'd2,
    WAIT_UP   = 2'd3
  } db_state_e;

endpackage

// File: rtl/key_event_if.sv
// Avalon-MM slave bus bundle for the key event controller.
interface key_event_if;

  logic [key_event_pkg::ADDR_W-1:0] address;
  logic                             chipselect;
  logic                             read;
  logic                             write;
  logic [key_event_pkg::DATA_W-1:0] writedata;
  logic [key_event_pkg::DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write, writedata,
    output readdata
  );

endinterface

// File: rtl/key_debounce.sv
// Per-key synchroniser and debounce FSM producing a clean level plus press/release pulses.
// Optional auto-repeat of press pulses while held: define KEY_EVENT_AUTO_REPEAT_EN.
module key_debounce
  import key_event_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DB_CNT_W        = 20,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]          sync;
  db_state_e           state;
  db_state_e           state_nxt;
  logic [DB_CNT_W-1:0] cnt;
  logic [DB_CNT_W-1:0] cnt_nxt;
  logic                level_nxt;
  logic                press_nxt;
  logic                release_nxt;
  logic                pressed_c;

  assign pressed_c = ~sync[1];

`ifdef KEY_EVENT_AUTO_REPEAT_EN
  localparam int unsigned      RPT_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

  logic [RPT_W-1:0] rpt;
  logic [RPT_W-1:0] rpt_nxt;
`else
  logic [31:0] unused_repeat;
  assign unused_repeat = 32'(REPEAT_CYCLES);
`endif

  // State register; synchroniser presets to released so reset never looks like a press
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync          <= 2'b11;
      state         <= UP;
      cnt           <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
`ifdef KEY_EVENT_AUTO_REPEAT_EN
      rpt           <= '0;
`endif
    end else begin
      sync          <= {sync[0], key_n};
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      level         <= level_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
`ifdef KEY_EVENT_AUTO_REPEAT_EN
      rpt           <= rpt_nxt;
`endif
    end
  end

  // Next state: a level is accepted only after DEBOUNCE_CYCLES consecutive stable samples
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      UP: begin
        if (pressed_c) begin
          state_nxt = WAIT_DOWN;
          cnt_nxt   = DB_CNT_W'(1);
        end
      end
      WAIT_DOWN: begin
        if (!pressed_c) begin
          state_nxt = UP;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = DOWN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + DB_CNT_W'(1);
        end
      end
      DOWN: begin
        if (!pressed_c) begin
          state_nxt = WAIT_UP;
          cnt_nxt   = DB_CNT_W'(1);
        end
      end
      WAIT_UP: begin
        if (pressed_c) begin
          state_nxt = DOWN;
          cnt_nxt   = '0;
        end else if (cnt == DB_LAST) begin
          state_nxt = UP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + DB_CNT_W'(1);
        end
      end
      default: begin
        state_nxt = UP;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the transition and registered alongside the state
  always_comb begin
    level_nxt   = (state_nxt == DOWN) || (state_nxt == WAIT_UP);
    press_nxt   = (state == WAIT_DOWN) && (state_nxt == DOWN);
    release_nxt = (state == WAIT_UP) && (state_nxt == UP);
`ifdef KEY_EVENT_AUTO_REPEAT_EN
    rpt_nxt = rpt;
    if ((state == DOWN) != (state_nxt == DOWN)) begin
      rpt_nxt = '0;
    end else if (state == DOWN) begin
      if (rpt == RPT_LAST) begin
        rpt_nxt   = '0;
        press_nxt = 1'b1;
      end else begin
        rpt_nxt = rpt + RPT_W'(1);
      end
    end
`endif
  end

endmodule

// File: rtl/key_event_ctrl.sv
// Avalon-MM key event controller: debounced levels, W1C press/release capture, masked level irq.
// Auto-repeat of held keys is enabled by defining KEY_EVENT_AUTO_REPEAT_EN.
module key_event_ctrl
  import key_event_pkg::*;
#(
  parameter int unsigned NUM_KEYS        = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned DB_CNT_W        = 20,
  parameter int unsigned REPEAT_CYCLES   = 25000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_KEYS-1:0] key_n,
  key_event_if.slave          bus,
  output logic                irq
);

  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] press_pulse;
  logic [NUM_KEYS-1:0] release_pulse;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .DB_CNT_W        (DB_CNT_W),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_db (
      .clk           (clk),
      .reset_n       (reset_n),
      .key_n         (key_n[k]),
      .level         (level[k]),
      .press_pulse   (press_pulse[k]),
      .release_pulse (release_pulse[k])
    );
  end

  logic                wr_c;
  logic                rd_c;
  logic                mask_wr_c;
  logic [NUM_KEYS-1:0] wdata_c;
  logic [NUM_KEYS-1:0] clr_press_c;
  logic [NUM_KEYS-1:0] clr_release_c;
  logic [DATA_W-1:0]   rdata_c;
  logic                unused_wdata_c;

  logic [NUM_KEYS-1:0] mask;
  logic [NUM_KEYS-1:0] press_cap;
  logic [NUM_KEYS-1:0] release_cap;

  assign wr_c           = bus.chipselect & bus.write;
  assign rd_c           = bus.chipselect & bus.read;
  assign wdata_c        = bus.writedata[NUM_KEYS-1:0];
  assign unused_wdata_c = ^bus.writedata;

  // Write decode; address 0 is read-only
  always_comb begin
    mask_wr_c     = 1'b0;
    clr_press_c   = '0;
    clr_release_c = '0;
    if (wr_c) begin
      unique case (bus.address)
        ADDR_MASK:    mask_wr_c     = 1'b1;
        ADDR_PRESS:   clr_press_c   = wdata_c;
        ADDR_RELEASE: clr_release_c = wdata_c;
        default:      ;
      endcase
    end
  end

  always_comb begin
    rdata_c = '0;
    unique case (bus.address)
      ADDR_LEVEL:   rdata_c = DATA_W'(level);
      ADDR_MASK:    rdata_c = DATA_W'(mask);
      ADDR_PRESS:   rdata_c = DATA_W'(press_cap);
      ADDR_RELEASE: rdata_c = DATA_W'(release_cap);
      default:      rdata_c = '0;
    endcase
  end

  // Set beats clear so an event landing on a W1C is never lost
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask         <= '0;
      press_cap    <= '0;
      release_cap  <= '0;
      irq          <= 1'b0;
      bus.readdata <= '0;
    end else begin
      if (mask_wr_c) begin
        mask <= wdata_c;
      end
      press_cap    <= (press_cap & ~clr_press_c) | press_pulse;
      release_cap  <= (release_cap & ~clr_release_c) | release_pulse;
      irq          <= |((press_cap | release_cap) & mask);
      bus.readdata <= rd_c ? rdata_c : '0;
    end
  end

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed self-checking bench for key_event_ctrl with a read-data scoreboard.
// Builds with or without KEY_EVENT_AUTO_REPEAT_EN.
module tb_key_event_ctrl;
  import key_event_pkg::*;

  localparam int unsigned NK  = 2;
  localparam int unsigned DB  = 8;
  localparam int unsigned RPT = 32;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic [NK-1:0] key_n   = '1;
  logic          irq;

  key_event_if bus ();

  key_event_ctrl #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (DB),
    .DB_CNT_W        (20),
    .REPEAT_CYCLES   (RPT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (key_n),
    .bus     (bus),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] exp_v;
  string       tag_v;
  logic        rd_issued = 1'b0;
  logic        mon_en    = 1'b0;
  int          key1_pulses = 0;

  wire [NK-1:0] press_p = {dut.g_key[1].u_db.press_pulse, dut.g_key[0].u_db.press_pulse};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) rd_issued <= bus.chipselect & bus.read;

  always @(negedge clk) if (press_p[1]) key1_pulses++;

  // Scoreboard: the cycle after a read pops the expected word, every other cycle readdata must be 0
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_issued) begin
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL rd_unexpected: observed 0x%0h expected no read", bus.readdata);
        end
        if (exp_q.size() != 0) begin
          exp_v = exp_q.pop_front();
          tag_v = tag_q.pop_front();
          check(tag_v, bus.readdata, exp_v);
        end
      end else begin
        check("rd_idle", bus.readdata, 32'h0);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] e, input string tag);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  // Counts negedges from the current one until key k pulses (bounded)
  task automatic wait_press(input int k, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!press_p[k] && n < 64);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int pq[$];
    logic seen;

    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.writedata  = '0;

    // Reset state
    cycles(3);
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    bus_read(ADDR_LEVEL,   32'h0, "rst_level");
    bus_read(ADDR_MASK,    32'h0, "rst_mask");
    bus_read(ADDR_PRESS,   32'h0, "rst_press");
    bus_read(ADDR_RELEASE, 32'h0, "rst_release");

    // Clean press of key0 held 20 cycles, then release
    key_n[0] = 1'b0;
    wait_press(0, n);
    check("press_lat", 32'(n), 32'd10);
    bus_read(ADDR_LEVEL, 32'h1, "level_pressed");
    bus_read(ADDR_PRESS, 32'h1, "press_cap");
    cycles(8);
    key_n[0] = 1'b1;
    cycles(14);
    bus_read(ADDR_RELEASE, 32'h1, "release_cap");
    bus_read(ADDR_LEVEL,   32'h0, "level_released");
    bus_write(ADDR_PRESS,   32'h3);
    bus_write(ADDR_RELEASE, 32'h3);
    bus_read(ADDR_PRESS,   32'h0, "press_w1c");
    bus_read(ADDR_RELEASE, 32'h0, "release_w1c");

    // Bounce on key1: never stable long enough
    key_n[1] = 1'b0; cycles(5);
    key_n[1] = 1'b1; cycles(3);
    key_n[1] = 1'b0; cycles(2);
    bus_read(ADDR_LEVEL, 32'h0, "bounce_level_mid");
    cycles(2);
    key_n[1] = 1'b1;
    cycles(15);
    bus_read(ADDR_LEVEL,   32'h0, "bounce_level");
    bus_read(ADDR_PRESS,   32'h0, "bounce_press");
    bus_read(ADDR_RELEASE, 32'h0, "bounce_release");
    check("bounce_pulses", 32'(key1_pulses), 32'h0);

    // IRQ path
    bus_write(ADDR_MASK, 32'h1);
    bus_read(ADDR_MASK, 32'h1, "mask_rb");
    key_n[0] = 1'b0;
    wait_press(0, n);
    check("press_lat_irq", 32'(n), 32'd10);
    @(negedge clk);
    check("irq_before_cap", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_set", 32'(irq), 32'h1);
    bus_write(ADDR_PRESS, 32'h1);
    check("irq_hold", 32'(irq), 32'h1);
    @(negedge clk);
    check("irq_clr", 32'(irq), 32'h0);
    key_n[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      seen = seen | irq;
    end
    check("irq_masked", 32'(seen), 32'h0);
    bus_read(ADDR_PRESS, 32'h2, "press_key1");
    key_n = 2'b11;
    cycles(14);
    bus_write(ADDR_MASK,    32'h0);
    bus_write(ADDR_PRESS,   32'h3);
    bus_write(ADDR_RELEASE, 32'h3);
    cycles(2);
    check("irq_idle", 32'(irq), 32'h0);
    bus_read(ADDR_RELEASE, 32'h0, "release_cleared");

    // W1C landing on the same edge as the press pulse
    key_n[0] = 1'b0;
    wait_press(0, n);
    check("press_lat_coll", 32'(n), 32'd10);
    bus_write(ADDR_PRESS, 32'h1);
    bus_read(ADDR_PRESS, 32'h1, "collision");

    // Release, then reset while in WAIT_UP
    bus_write(ADDR_MASK, 32'h1);
    @(negedge clk);
    check("irq_pre_reset", 32'(irq), 32'h1);
    key_n[0] = 1'b1;
    cycles(5);
    reset_n = 1'b0;
    #1;
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_readdata", bus.readdata, 32'h0);
    cycles(3);
    reset_n = 1'b1;
    cycles(20);
    check("post_reset_irq", 32'(irq), 32'h0);
    bus_read(ADDR_LEVEL,   32'h0, "post_reset_level");
    bus_read(ADDR_MASK,    32'h0, "post_reset_mask");
    bus_read(ADDR_PRESS,   32'h0, "post_reset_press");
    bus_read(ADDR_RELEASE, 32'h0, "post_reset_release");

    // Long hold: auto-repeat pulse schedule
`ifdef KEY_EVENT_AUTO_REPEAT_EN
    pq = '{10, 42, 74, 106};
`else
    pq = '{10};
`endif
    key_n[0] = 1'b0;
    for (int i = 1; i <= 115; i++) begin
      @(negedge clk);
      if (press_p[0]) begin
        tests++;
        assert (pq.size() != 0) else begin
          fails++;
          $error("FAIL repeat_extra: observed pulse at %0d expected none", i);
        end
        if (pq.size() != 0) check("repeat_time", 32'(i), 32'(pq.pop_front()));
      end
    end
    check("repeat_missing", 32'(pq.size()), 32'h0);
    key_n[0] = 1'b1;
    cycles(14);
    bus_read(ADDR_RELEASE, 32'h1, "repeat_release");
    bus_read(ADDR_PRESS,   32'h1, "repeat_press");
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
